// File: rtl/bpu_pkg.sv
// Shared constants for the branch predict unit: branch condition codes and
// 2-bit saturating counter encodings with their step function.
package bpu_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;

  // Saturating step toward the resolved direction.
  function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = ctr_e'(cur + 2'd1);
    end else begin
      if (cur != SNT) nxt = ctr_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Purely combinational evaluation of a conditional branch's func3 compare.
// legal_o is low for the two func3 codes that are not branch conditions.
module branch_cond_eval
  import bpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            taken_o,
  output logic            legal_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (data1_i == data2_i);
  assign lt_s = ($signed(data1_i) < $signed(data2_i));
  assign lt_u = (data1_i < data2_i);

  always_comb begin
    taken_o = 1'b0;
    legal_o = 1'b1;
    case (func3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = !eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = !lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = !lt_u;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor and resolver: 2-bit counter table + tagged BTB looked up in IF,
// branches/jumps resolved in EX. Define BPU_PERF_EN to add performance counters.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int CNT_W      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_data1,
  input  logic [XLEN-1:0] ex_data2,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
`ifdef BPU_PERF_EN
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
`endif
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = XLEN - INDEX_BITS - 2;

  ctr_e            ctr_q   [ENTRIES];
  logic            valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q  [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];

  // IF lookup
  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]      if_tag;
  logic                  if_hit;
  logic                  if_ctr_taken;

  assign if_idx       = if_pc[INDEX_BITS+1:2];
  assign if_tag       = if_pc[XLEN-1:INDEX_BITS+2];
  assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_ctr_taken = (ctr_q[if_idx] == WT) || (ctr_q[if_idx] == ST);

  always_comb begin
    if_pred_taken  = if_hit && if_ctr_taken;
    if_pred_target = if_pc + XLEN'(4);
    if (if_pred_taken) if_pred_target = tgt_q[if_idx];
  end

  // EX resolution
  logic            cond_taken;
  logic            cond_legal;
  logic            ex_cf;
  logic            res_taken;
  logic            res_legal;
  logic [XLEN-1:0] ex_seq_pc;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .func3_i (ex_func3),
    .data1_i (ex_data1),
    .data2_i (ex_data2),
    .taken_o (cond_taken),
    .legal_o (cond_legal)
  );

  assign ex_cf     = ex_valid && (ex_branch || ex_jump);
  assign res_legal = ex_jump || cond_legal;
  assign res_taken = ex_cf && (ex_jump || (cond_taken && cond_legal));
  assign ex_seq_pc = ex_pc + XLEN'(4);

  always_comb begin
    redirect_pc = res_taken ? ex_alu_result : ex_seq_pc;
    mispredict  = 1'b0;
    if (ex_cf) begin
      mispredict = (res_taken != ex_pred_taken) ||
                   (res_taken && (ex_alu_result != ex_pred_target));
    end else if (ex_valid) begin
      // A non-control instruction predicted taken came from an aliased entry.
      mispredict = ex_pred_taken;
    end
  end

  // Table update
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_hit;
  logic                  upd_en;
  logic                  ctr_we;
  logic                  btb_we;
  ctr_e                  ctr_d;

  assign upd_idx = ex_pc[INDEX_BITS+1:2];
  assign upd_tag = ex_pc[XLEN-1:INDEX_BITS+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_en  = ex_cf && res_legal;

  always_comb begin
    ctr_d  = ctr_step(ctr_q[upd_idx], res_taken);
    ctr_we = 1'b0;
    btb_we = 1'b0;
    if (upd_en) begin
      if (res_taken) begin
        btb_we = 1'b1;
        ctr_we = 1'b1;
        if (!upd_hit) ctr_d = WT;
      end else begin
        // Not-taken misses leave another branch's entry undisturbed.
        ctr_we = upd_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]   <= CTR_RESET;
        valid_q[i] <= 1'b0;
      end
    end else begin
      if (ctr_we) ctr_q[upd_idx] <= ctr_d;
      if (btb_we) valid_q[upd_idx] <= 1'b1;
    end
  end

  // Tag/target storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && btb_we) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= ex_alu_result;
    end
  end

`ifdef BPU_PERF_EN
  logic [CNT_W-1:0] branch_count_q;
  logic [CNT_W-1:0] branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q;
  logic [CNT_W-1:0] mispredict_count_d;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (ex_cf)      branch_count_d     = branch_count_q + CNT_W'(1);
    if (mispredict) mispredict_count_d = mispredict_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  // CNT_W only sizes the compiled-out counters.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by
// randomized traffic against an array-based reference model.
module tb_branch_predict_unit;

  localparam int XLEN = 32;
  localparam int N    = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_branch;
  logic        ex_jump;
  logic [2:0]  ex_func3;
  logic [31:0] ex_data1;
  logic [31:0] ex_data2;
  logic [31:0] ex_alu_result;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BPU_PERF_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic [31:0] m_bc;
  logic [31:0] m_mc;
`endif

  branch_predict_unit #(.XLEN(32), .INDEX_BITS(6), .CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_branch      (ex_branch),
    .ex_jump        (ex_jump),
    .ex_func3       (ex_func3),
    .ex_data1       (ex_data1),
    .ex_data2       (ex_data2),
    .ex_alu_result  (ex_alu_result),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
`ifdef BPU_PERF_EN
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
`endif
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per-entry counter value 0..3, valid, tag and target.
  int          m_ctr   [N];
  bit          m_valid [N];
  logic [23:0] m_tag   [N];
  logic [31:0] m_tgt   [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ctr[i]   = 1;
      m_valid[i] = 1'b0;
    end
`ifdef BPU_PERF_EN
    m_bc = 0;
    m_mc = 0;
`endif
  endtask

  task automatic model_lookup(input logic [31:0] pc, output bit taken, output logic [31:0] tgt);
    int i;
    bit hit;
    i     = int'(pc[7:2]);
    hit   = m_valid[i] && (m_tag[i] == pc[31:8]);
    taken = hit && (m_ctr[i] >= 2);
    tgt   = taken ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_resolve(output bit taken, output bit legal);
    taken = 1'b0;
    legal = 1'b0;
    if (ex_valid && (ex_branch || ex_jump)) begin
      if (ex_jump) begin
        taken = 1'b1;
        legal = 1'b1;
      end else begin
        legal = 1'b1;
        case (ex_func3)
          3'd0: taken = (ex_data1 == ex_data2);
          3'd1: taken = (ex_data1 != ex_data2);
          3'd4: taken = ($signed(ex_data1) <  $signed(ex_data2));
          3'd5: taken = ($signed(ex_data1) >= $signed(ex_data2));
          3'd6: taken = (ex_data1 <  ex_data2);
          3'd7: taken = (ex_data1 >= ex_data2);
          default: legal = 1'b0;
        endcase
      end
    end
  endtask

  // Checks all outputs against the model, then clocks and advances the model.
  task automatic step();
    bit          p_taken, r_taken, r_legal, e_mis, hit;
    logic [31:0] p_tgt, e_redir;
    int          i;
    #1;
    model_lookup(if_pc, p_taken, p_tgt);
    model_resolve(r_taken, r_legal);
    if (ex_valid && (ex_branch || ex_jump))
      e_mis = (r_taken != ex_pred_taken) || (r_taken && ex_alu_result != ex_pred_target);
    else
      e_mis = ex_valid && ex_pred_taken;
    e_redir = r_taken ? ex_alu_result : ex_pc + 32'd4;
    check("pred_taken", {31'd0, if_pred_taken}, {31'd0, p_taken});
    check("pred_target", if_pred_target, p_tgt);
    check("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
    if (e_mis) check("redirect_pc", redirect_pc, e_redir);
`ifdef BPU_PERF_EN
    check("branch_count", branch_count, m_bc);
    check("mispredict_count", mispredict_count, m_mc);
`endif
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
`ifdef BPU_PERF_EN
      if (ex_valid && (ex_branch || ex_jump)) m_bc = m_bc + 1;
      if (e_mis) m_mc = m_mc + 1;
`endif
      if (r_legal) begin
        i   = int'(ex_pc[7:2]);
        hit = m_valid[i] && (m_tag[i] == ex_pc[31:8]);
        if (r_taken) begin
          m_ctr[i]   = hit ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : 2;
          m_valid[i] = 1'b1;
          m_tag[i]   = ex_pc[31:8];
          m_tgt[i]   = ex_alu_result;
        end else if (hit) begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end
    end
    #1;
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] t, ix;
    t  = 32'($urandom_range(0, 2));
    ix = 32'($urandom_range(0, 7));
    return (t << 8) | (ix << 2);
  endfunction

  function automatic logic [31:0] pick_tgt();
    logic [31:0] t;
    t = 32'($urandom_range(0, 3));
    return 32'h100 + (t << 6);
  endfunction

  function automatic logic [31:0] pick_data();
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 7)) - 32'd4;
    return $urandom;
  endfunction

  initial begin
    bit          lt;
    logic [31:0] lg;
    int          r;

    reset = 1'b1;
    if_pc = 32'h40;
    ex_valid = 1'b0; ex_pc = 32'h0; ex_branch = 1'b0; ex_jump = 1'b0;
    ex_func3 = 3'd0; ex_data1 = 32'h0; ex_data2 = 32'h0;
    ex_alu_result = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;

    // Reset lookup
    if_pc = 32'h40;
    #1;
    check("rst_pred_taken", {31'd0, if_pred_taken}, 32'd0);
    check("rst_pred_target", if_pred_target, 32'h44);
    step();

    // BEQ trained taken over three executions
    ex_valid = 1'b1; ex_branch = 1'b1; ex_jump = 1'b0; ex_func3 = 3'd0;
    ex_pc = 32'h40; ex_data1 = 32'd5; ex_data2 = 32'd5; ex_alu_result = 32'h80;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h44;
    #1;
    check("beq1_mispredict", {31'd0, mispredict}, 32'd1);
    check("beq1_redirect", redirect_pc, 32'h80);
    step();
    model_lookup(32'h40, lt, lg);
    ex_pred_taken = lt; ex_pred_target = lg;
    step();
    model_lookup(32'h40, lt, lg);
    ex_pred_taken = lt; ex_pred_target = lg;
    #1;
    check("beq3_pred_taken", {31'd0, if_pred_taken}, 32'd1);
    check("beq3_pred_target", if_pred_target, 32'h80);
    check("beq3_mispredict", {31'd0, mispredict}, 32'd0);
    step();

    // Signed vs unsigned less-than on -15 vs 12
    ex_pc = 32'h60; ex_func3 = 3'd4; ex_data1 = -32'sd15; ex_data2 = 32'd12;
    ex_alu_result = 32'h90; ex_pred_taken = 1'b0; ex_pred_target = 32'h64;
    #1;
    check("blt_mispredict", {31'd0, mispredict}, 32'd1);
    check("blt_redirect", redirect_pc, 32'h90);
    step();
    ex_pc = 32'h70; ex_func3 = 3'd6;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h74;
    #1;
    check("bltu_mispredict", {31'd0, mispredict}, 32'd0);
    check("bltu_redirect", redirect_pc, 32'h74);
    step();

    // Index alias with different tag
    ex_valid = 1'b0;
    if_pc = 32'h140;
    #1;
    check("alias_pred_taken", {31'd0, if_pred_taken}, 32'd0);
    check("alias_pred_target", if_pred_target, 32'h144);
    step();

    // JALR with wrong predicted target, then a bubble must not update
    ex_valid = 1'b1; ex_branch = 1'b0; ex_jump = 1'b1; ex_func3 = 3'd0;
    ex_pc = 32'h10; ex_alu_result = 32'h200;
    ex_pred_taken = 1'b1; ex_pred_target = 32'h100;
    #1;
    check("jalr_mispredict", {31'd0, mispredict}, 32'd1);
    check("jalr_redirect", redirect_pc, 32'h200);
    step();
    ex_valid = 1'b0; ex_alu_result = 32'h300;
    if_pc = 32'h10;
    #1;
    check("bubble_mispredict", {31'd0, mispredict}, 32'd0);
    check("jalr_pred_target", if_pred_target, 32'h200);
    step();
    #1;
    check("bubble_no_update", if_pred_target, 32'h200);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      if_pc    = pick_pc();
      ex_pc    = pick_pc();
      ex_valid = ($urandom_range(0, 9) != 0);
      r        = int'($urandom_range(0, 9));
      ex_branch = (r <= 5);
      ex_jump   = (r == 6) || (r == 7);
      ex_func3  = 3'($urandom_range(0, 7));
      ex_data1  = pick_data();
      ex_data2  = ($urandom_range(0, 3) == 0) ? ex_data1 : pick_data();
      ex_alu_result = pick_tgt();
      if ($urandom_range(0, 2) != 0) begin
        model_lookup(ex_pc, lt, lg);
        ex_pred_taken = lt; ex_pred_target = lg;
      end else begin
        ex_pred_taken  = 1'($urandom_range(0, 1));
        ex_pred_target = pick_tgt();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
